// File: rtl/fluid_pkg.sv
// Shared Q16.16 fixed-point types and saturating arithmetic for the fluid pipeline stages.
package fluid_pkg;

    typedef logic signed [31:0] fix_t;

    localparam int   FRAC_BITS = 16;
    localparam fix_t FIX_ONE   = 32'sh0001_0000;

    localparam logic signed [63:0] FIX_MAX64 = 64'sd2147483647;
    localparam logic signed [63:0] FIX_MIN64 = -64'sd2147483648;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DOT_X = 3'd1,
        DOT_Y = 3'd2,
        SCALE = 3'd3,
        UPD_X = 3'd4,
        UPD_Y = 3'd5
    } state_t;

    // Callers sign-extend 33-bit sums to 64 bits before clamping.
    function automatic fix_t sat32(input logic signed [63:0] x);
        if (x > FIX_MAX64) begin
            return 32'sh7FFF_FFFF;
        end else if (x < FIX_MIN64) begin
            return 32'sh8000_0000;
        end
        return x[31:0];
    endfunction

    function automatic fix_t fx_mul(input fix_t a, input fix_t b);
        logic signed [63:0] prod;
        prod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return sat32(prod >>> FRAC_BITS);
    endfunction

    function automatic fix_t sat_add(input fix_t a, input fix_t b);
        logic signed [32:0] s;
        s = $signed({a[31], a}) + $signed({b[31], b});
        return sat32($signed({{31{s[32]}}, s}));
    endfunction

    function automatic fix_t sat_sub(input fix_t a, input fix_t b);
        logic signed [32:0] s;
        s = $signed({a[31], a}) - $signed({b[31], b});
        return sat32($signed({{31{s[32]}}, s}));
    endfunction

endpackage

// File: rtl/vel_reflect_if.sv
// Start/done request bundle for the velocity reflection stage.
interface vel_reflect_if;
    import fluid_pkg::*;

    logic start;
    fix_t vx;
    fix_t vy;
    fix_t nx;
    fix_t ny;
    fix_t vxo;
    fix_t vyo;
    logic hit;
    logic done;

    modport master (output start, vx, vy, nx, ny, input vxo, vyo, hit, done);
    modport slave  (input start, vx, vy, nx, ny, output vxo, vyo, hit, done);
endinterface

// File: rtl/fx_mul.sv
// Combinational Q16.16 multiplier: floor shift and saturation to 32 bits.
module fx_mul (
    input  fluid_pkg::fix_t a,
    input  fluid_pkg::fix_t b,
    output fluid_pkg::fix_t p
);

    assign p = fluid_pkg::fx_mul(a, b);

endmodule

// File: rtl/vel_reflect.sv
// Reflects a velocity off a boundary with restitution: v' = v - COEF*(v.n)*n when v.n < 0.
// state | meaning
// IDLE  | wait for start, latch operands
// DOT_X | acc = vx*nx
// DOT_Y | acc += vy*ny
// SCALE | k = acc*COEF if moving into the wall, else 0
// UPD_X | vxo = vx - k*nx
// UPD_Y | vyo = vy - k*ny, present hit and done
module vel_reflect
    import fluid_pkg::*;
#(
    parameter fix_t COEF = 32'sh0001_CCCD
) (
    input logic          clk,
    input logic          rst_n,
    vel_reflect_if.slave bus
);

    state_t state;
    fix_t   vx_r, vy_r, nx_r, ny_r;
    fix_t   acc, k;
    logic   hit_r;
    fix_t   mul_a, mul_b, mul_p;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            DOT_X: begin mul_a = vx_r; mul_b = nx_r; end
            DOT_Y: begin mul_a = vy_r; mul_b = ny_r; end
            SCALE: begin mul_a = acc;  mul_b = COEF; end
            UPD_X: begin mul_a = k;    mul_b = nx_r; end
            UPD_Y: begin mul_a = k;    mul_b = ny_r; end
            default: ;
        endcase
    end

    fx_mul u_mul (
        .a (mul_a),
        .b (mul_b),
        .p (mul_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            vx_r     <= '0;
            vy_r     <= '0;
            nx_r     <= '0;
            ny_r     <= '0;
            acc      <= '0;
            k        <= '0;
            hit_r    <= 1'b0;
            bus.vxo  <= '0;
            bus.vyo  <= '0;
            bus.hit  <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        vx_r  <= bus.vx;
                        vy_r  <= bus.vy;
                        nx_r  <= bus.nx;
                        ny_r  <= bus.ny;
                        state <= DOT_X;
                    end
                end
                DOT_X: begin
                    acc   <= mul_p;
                    state <= DOT_Y;
                end
                DOT_Y: begin
                    acc   <= sat_add(acc, mul_p);
                    state <= SCALE;
                end
                SCALE: begin
                    // A tangential velocity (acc == 0) passes through untouched.
                    if (acc < 0) begin
                        k     <= mul_p;
                        hit_r <= 1'b1;
                    end else begin
                        k     <= '0;
                        hit_r <= 1'b0;
                    end
                    state <= UPD_X;
                end
                UPD_X: begin
                    bus.vxo <= sat_sub(vx_r, mul_p);
                    state   <= UPD_Y;
                end
                UPD_Y: begin
                    bus.vyo  <= sat_sub(vy_r, mul_p);
                    bus.hit  <= hit_r;
                    bus.done <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vel_reflect.sv
// Directed checks of vel_reflect: reflection results, latency, ignored start, mid-op reset.
module tb_vel_reflect;
    import fluid_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   done_cnt;

    vel_reflect_if bus ();

    vel_reflect #(.COEF(32'sh0001_CCCD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (bus.done) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic launch(input fix_t a, input fix_t b, input fix_t c, input fix_t d);
        @(negedge clk);
        bus.vx    = a;
        bus.vy    = b;
        bus.nx    = c;
        bus.ny    = d;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_case(input string tag, input fix_t a, input fix_t b, input fix_t c,
                            input fix_t d, input fix_t exp_x, input fix_t exp_y, input logic exp_hit);
        int lat;
        launch(a, b, c, d);
        wait_done(lat);
        chk({tag, "_lat"}, 32'(lat), 32'd5);
        chk({tag, "_vxo"}, bus.vxo, exp_x);
        chk({tag, "_vyo"}, bus.vyo, exp_y);
        chk({tag, "_hit"}, {31'd0, bus.hit}, {31'd0, exp_hit});
        @(posedge clk);
        #1;
        chk({tag, "_done_fall"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        int lat;
        int cnt0;
        total     = 0;
        bad       = 0;
        done_cnt  = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.vx    = '0;
        bus.vy    = '0;
        bus.nx    = '0;
        bus.ny    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vxo", bus.vxo, 32'h0);
        chk("rst_vyo", bus.vyo, 32'h0);
        chk("rst_hit", {31'd0, bus.hit}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        run_case("head_on", 32'shFFFE_0000, 32'sh0, FIX_ONE, 32'sh0,
                 32'sh0001_999A, 32'sh0, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("hold_vxo", bus.vxo, 32'h0001_999A);
        chk("hold_hit", {31'd0, bus.hit}, 32'd1);

        run_case("away", 32'sh0003_0000, 32'sh0001_0000, FIX_ONE, 32'sh0,
                 32'sh0003_0000, 32'sh0001_0000, 1'b0);
        run_case("diag", 32'shFFFF_0000, 32'shFFFF_0000, 32'sd46341, 32'sd46341,
                 32'sh0000_CCCE, 32'sh0000_CCCE, 1'b1);
        run_case("ksat", 32'sh8001_0000, 32'sh0, FIX_ONE, 32'sh0,
                 32'sh0001_0000, 32'sh0, 1'b1);
        run_case("tangent", 32'sh0, 32'sh0002_0000, FIX_ONE, 32'sh0,
                 32'sh0, 32'sh0002_0000, 1'b0);

        // Second start while busy, with different operands, must be dropped.
        cnt0 = done_cnt;
        launch(32'shFFFE_0000, 32'sh0, FIX_ONE, 32'sh0);
        @(posedge clk);
        #1;
        bus.vx    = 32'sh0003_0000;
        bus.vy    = 32'sh0001_0000;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(lat);
        chk("busy_lat", 32'(lat), 32'd3);
        chk("busy_vxo", bus.vxo, 32'h0001_999A);
        chk("busy_vyo", bus.vyo, 32'h0);
        chk("busy_hit", {31'd0, bus.hit}, 32'd1);
        repeat (10) @(posedge clk);
        #1;
        chk("busy_done_cnt", 32'(done_cnt - cnt0), 32'd1);

        // Reset while in SCALE aborts the request.
        launch(32'shFFFF_0000, 32'shFFFF_0000, 32'sd46341, 32'sd46341);
        @(posedge clk);
        @(posedge clk);
        #1;
        cnt0  = done_cnt;
        rst_n = 1'b0;
        #2;
        chk("abort_vxo", bus.vxo, 32'h0);
        chk("abort_vyo", bus.vyo, 32'h0);
        chk("abort_hit", {31'd0, bus.hit}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_cnt - cnt0), 32'd0);
        run_case("after_rst", 32'shFFFE_0000, 32'sh0, FIX_ONE, 32'sh0,
                 32'sh0001_999A, 32'sh0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
